// File: rtl/euler_result_reporter.sv
// Reports a solver answer as ASCII decimal over a valid/ready byte stream.
// The capture is converted by a sequential double-dabble, leading zeros are skipped and EOL closes it.
module euler_result_reporter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned DIGITS   = 20,
  parameter logic [7:0]  EOL_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] result,
  input  logic              done,
  input  logic              error,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              report_done
);

  localparam int unsigned IterW = $clog2(DATA_W + 1);
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IterW-1:0] IterLast = IterW'(DATA_W - 1);
  localparam logic [IdxW-1:0]  IdxTop   = IdxW'(DIGITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StSkip,
    StSend,
    StEol,
    StErrmsg
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_step;
  logic [IterW-1:0]    iter_q, iter_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [1:0]          err_cnt_q, err_cnt_d;
  logic                done_q, error_q;
  logic                report_done_q, report_done_d;
  logic                trig_done, trig_err, accept;
  logic [3:0]          cur_digit;

  assign trig_done = done & ~done_q;
  assign trig_err  = error & ~error_q;
  assign accept    = char_valid & char_ready;
  assign cur_digit = bcd_q[4*idx_q +: 4];

  // One double-dabble step: correct each digit, then shift {bcd, shift} left by one.
  // The correction's carry-out of the top digit is dropped; the sizing guarantees it stays 0.
  always_comb begin : dd_step
    logic [3:0] d;
    logic       cin;
    cin      = shift_q[DATA_W-1];
    bcd_step = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = bcd_q[4*i +: 4];
      if (d >= 4'd5) d = d + 4'd3;
      bcd_step[4*i +: 4] = {d[2:0], cin};
      cin = d[3];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      bcd_q         <= '0;
      iter_q        <= '0;
      idx_q         <= '0;
      err_cnt_q     <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      report_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bcd_q         <= bcd_d;
      iter_q        <= iter_d;
      idx_q         <= idx_d;
      err_cnt_q     <= err_cnt_d;
      done_q        <= done;
      error_q       <= error;
      report_done_q <= report_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bcd_d         = bcd_q;
    iter_d        = iter_q;
    idx_d         = idx_q;
    err_cnt_d     = err_cnt_q;
    report_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Error wins when both edges land in the same cycle.
        if (trig_err) begin
          state_d   = StErrmsg;
          err_cnt_d = '0;
        end else if (trig_done) begin
          state_d = StConvert;
          shift_d = result;
          bcd_d   = '0;
          iter_d  = '0;
        end
      end
      StConvert: begin
        shift_d = shift_q << 1;
        bcd_d   = bcd_step;
        iter_d  = iter_q + IterW'(1);
        if (iter_q == IterLast) begin
          state_d = StSkip;
          idx_d   = IdxTop;
        end
      end
      StSkip: begin
        if (cur_digit == 4'd0 && idx_q != '0) idx_d = idx_q - IdxW'(1);
        else state_d = StSend;
      end
      StSend: begin
        if (accept) begin
          if (idx_q == '0) state_d = StEol;
          else idx_d = idx_q - IdxW'(1);
        end
      end
      StEol: begin
        if (accept) begin
          state_d       = StIdle;
          report_done_d = 1'b1;
        end
      end
      StErrmsg: begin
        if (accept) begin
          if (err_cnt_q == 2'd2) state_d = StEol;
          else err_cnt_d = err_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only, so char_valid never depends on char_ready.
  always_comb begin
    busy        = (state_q != StIdle);
    report_done = report_done_q;
    char_valid  = 1'b0;
    char_data   = 8'h00;
    unique case (state_q)
      StSend: begin
        char_valid = 1'b1;
        char_data  = 8'h30 + {4'h0, cur_digit};
      end
      StEol: begin
        char_valid = 1'b1;
        char_data  = EOL_CHAR;
      end
      StErrmsg: begin
        char_valid = 1'b1;
        char_data  = (err_cnt_q == 2'd0) ? 8'h45 : 8'h52;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_euler_result_reporter.sv
// Bench for euler_result_reporter: table vectors, random reports against a decimal-string model,
// and hand sequences for held levels, edges while busy and reset during streaming.
module tb_euler_result_reporter;

  localparam int DataW  = 64;
  localparam int Digits = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] result;
  logic        done;
  logic        error;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        report_done;

  euler_result_reporter #(
    .DATA_W  (DataW),
    .DIGITS  (Digits),
    .EOL_CHAR(8'h0A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .result     (result),
    .done       (done),
    .error      (error),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .report_done(report_done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int rd_cnt  = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] rx[$];

  logic       pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic string hexs(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  task automatic check_str(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got [%s] want [%s]", name, hexs(act), hexs(exp));
  endtask

  function automatic string rx_str();
    string s = "";
    foreach (rx[i]) s = {s, $sformatf("%c", rx[i])};
    return s;
  endfunction

  // Cycles from raising the trigger to first visible char_valid.
  function automatic int lat_for(input string exp, input bit er);
    return er ? 1 : 2 + DataW + Digits - (exp.len() - 1);
  endfunction

  // Values seen at a negedge are the ones the following posedge samples.
  always @(negedge clk) begin
    if (char_valid && char_ready && rst_n) rx.push_back(char_data);
    if (report_done) rd_cnt <= rd_cnt + 1;
    if (pv && !pr && prst) begin
      check("stall_valid", char_valid, 1'b1);
      check("stall_data", char_data, pd);
    end
    pv   <= char_valid;
    pr   <= char_ready;
    pd   <= char_data;
    prst <= rst_n;
  end

  initial begin
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      char_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_report(input string name, input logic [63:0] val, input bit dn, input bit er,
                           input bit rr, input string exp, input int exp_lat);
    int lat;
    int n0;
    bit seen;
    lat = 0;
    seen = 1'b0;
    rand_rdy = rr;
    rx.delete();
    n0 = rd_cnt;
    result = val;
    done = dn;
    error = er;
    for (int c = 0; c < 4000 && rd_cnt == n0; c++) begin
      tick();
      if (!seen) begin
        lat++;
        seen = char_valid;
      end
    end
    repeat (5) tick();  // levels still high: must not start another report
    done = 1'b0;
    error = 1'b0;
    rand_rdy = 1'b0;
    repeat (2) tick();
    check_str({name, "_bytes"}, rx_str(), exp);
    check({name, "_pulses"}, 64'(rd_cnt - n0), 64'd1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  typedef struct {
    logic [63:0] val;
    bit          dn;
    bit          er;
    bit          rr;
    string       exp;
  } vec_t;

  vec_t        tbl[6];
  logic [63:0] v;
  bit          e;
  string       exp_s;
  int          n0;

  initial begin
    tbl[0] = '{64'd142913828922, 1'b1, 1'b0, 1'b0, "142913828922\n"};
    tbl[1] = '{64'd0, 1'b1, 1'b0, 1'b0, "0\n"};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, "18446744073709551615\n"};
    tbl[3] = '{64'd55, 1'b0, 1'b1, 1'b0, "ERR\n"};
    tbl[4] = '{64'd77, 1'b1, 1'b1, 1'b0, "ERR\n"};
    tbl[5] = '{64'd1000, 1'b1, 1'b0, 1'b1, "1000\n"};

    rst_n = 1'b0;
    done = 1'b0;
    error = 1'b0;
    result = '0;
    repeat (3) tick();
    check("rst_valid", char_valid, 1'b0);
    check("rst_data", char_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_rdone", report_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++)
      do_report($sformatf("vec%0d", i), tbl[i].val, tbl[i].dn, tbl[i].er, tbl[i].rr, tbl[i].exp,
                lat_for(tbl[i].exp, tbl[i].er));

    // done held ~500 cycles with an extra edge while converting: one report only.
    rx.delete();
    n0 = rd_cnt;
    result = 64'd7;
    done = 1'b1;
    repeat (10) tick();
    check("held_busy", busy, 1'b1);
    done = 1'b0;
    tick();
    done = 1'b1;
    repeat (489) tick();
    check_str("held_bytes", rx_str(), "7\n");
    check("held_pulses", 64'(rd_cnt - n0), 64'd1);
    done = 1'b0;
    tick();
    do_report("rerise", 64'd7, 1'b1, 1'b0, 1'b0, "7\n", lat_for("7\n", 1'b0));

    // Reset during SEND abandons the report.
    rx.delete();
    result = 64'd142913828922;
    done = 1'b1;
    for (int c = 0; c < 500 && rx.size() < 3; c++) tick();
    check("mid_send_valid", char_valid, 1'b1);
    rst_n = 1'b0;
    done = 1'b0;
    tick();
    check("mid_rst_valid", char_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", char_data, 8'h00);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", busy, 1'b0);
    do_report("after_rst", 64'd142913828922, 1'b1, 1'b0, 1'b0, "142913828922\n",
              lat_for("142913828922\n", 1'b0));

    // A level already high as reset releases triggers once.
    rst_n = 1'b0;
    done = 1'b1;
    result = 64'd5;
    repeat (2) tick();
    check("lvl_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    do_report("lvl_rst", 64'd5, 1'b1, 1'b0, 1'b0, "5\n", lat_for("5\n", 1'b0));

    for (int k = 0; k < 24; k++) begin
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      e = ($urandom_range(0, 4) == 0);
      exp_s = e ? "ERR\n" : $sformatf("%0d\n", v);
      do_report($sformatf("rnd%0d", k), v, !e || 1'($urandom_range(0, 1)), e,
                1'($urandom_range(0, 1)), exp_s, lat_for(exp_s, e));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/euler_result_reporter.md
Name: euler_result_reporter

Overview:
- Hardware consumer for the solver result interface used by every Euler problem core: 64-bit `result`, `done`, `error`.
- Captures the result when a solver finishes and converts it to decimal with a sequential double-dabble.
- Streams the answer as ASCII characters over a valid/ready byte interface, for a UART TX or a character sink.
- Instantiated beside a problem core (e.g. p0010) so answers are reported on silicon without a simulator `$display`.

Parameters:
- DATA_W, 64, width of the `result` input.
- DIGITS, 20, BCD digit count. Must satisfy 10^DIGITS > 2^DATA_W.
- EOL_CHAR, 8'h0A, terminator byte emitted after every report.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- result  input  DATA_W  solver answer; valid when `done` is high.
- done  input  1  solver completion level.
- error  input  1  solver error level.
- char_data  output  8  ASCII byte.
- char_valid  output  1  `char_data` is valid.
- char_ready  input  1  sink accepts the byte.
- busy  output  1  a report is in progress (not IDLE).
- report_done  output  1  one-cycle pulse after the EOL byte is accepted.

Behaviour:
- Reset (rst_n low at a posedge): state=IDLE; char_valid=0; char_data=0; busy=0; report_done=0; done_q=0; error_q=0.
  - Reset has priority over everything, including mid-conversion and mid-stream. The next cycle is IDLE with char_valid=0, and any partial report is abandoned.
- Edge detect:
  - done_q and error_q register `done` and `error` every cycle.
  - Trigger = (done & ~done_q) | (error & ~error_q), sampled only in IDLE.
  - done_q/error_q reset to 0, so a level already high when reset deasserts triggers once.
  - Edges arriving while busy are ignored and never queued. A level held high triggers once.
- Simultaneous: done and error both rising in the same cycle gives an error report.
- States:
  - IDLE:
    - On an error trigger, go to ERRMSG.
    - On a done trigger, latch `result` into shift reg, clear the BCD reg, set iter=0 and go to CONVERT.
    - Otherwise stay.
  - CONVERT: per cycle, add 3 to each BCD digit ≥5, then shift {bcd,shift} left by 1.
    - Exactly DATA_W cycles (iter 0..DATA_W-1), then set digit index = DIGITS-1 and go to SKIP.
  - SKIP: if the current digit is 0 and index > 0, decrement the index, one per cycle. Otherwise go to SEND.
    - Value 0 therefore emits a single "0".
  - SEND:
    - char_valid=1, char_data = 8'h30 + digit[index].
    - On char_valid & char_ready: if index=0 go to EOL, else decrement the index.
  - EOL: char_valid=1, char_data=EOL_CHAR. On accept, pulse report_done and go to IDLE.
  - ERRMSG: emits "E","R","R" (8'h45, 8'h52, 8'h52), one per accept, then goes to EOL.
- Handshake:
  - A byte transfers on a posedge with char_valid & char_ready.
  - While char_valid=1 and char_ready=0, char_data is held stable and char_valid does not drop.
  - char_valid is registered, not combinational from char_ready.
  - Back-to-back accepts are supported, one byte per cycle.
- Latency for a done report with char_ready=1 throughout:
  - Trigger cycle T, IDLE→CONVERT at T+1.
  - CONVERT occupies DATA_W cycles.
  - SKIP occupies (leading zeros + 1) cycles.
  - The first char_valid follows, then one byte per cycle.
- Widths:
  - BCD register is 4*DIGITS bits; DATA_W-bit shift register; iter counter is clog2(DATA_W+1) bits.
  - The add-3 correction uses no carry out of a digit.
- busy=1 in every state except IDLE. report_done=0 except for its pulse.

Test Plan:
- done rises with result=142913828922, char_ready=1 → bytes "142913828922\n" (0x31 0x34 0x32 0x39 0x31 0x33 0x38 0x32 0x38 0x39 0x32 0x32 0x0A), one report_done pulse, busy back to 0.
- result=0, done rises → "0\n" exactly. result=64'hFFFF_FFFF_FFFF_FFFF → "18446744073709551615\n" (20 digits, no leading-zero issue).
- error rises, and separately done and error rise together → "ERR\n" (0x45 0x52 0x52 0x0A) in both cases, with no digits emitted.
- char_ready randomly deasserted (≈50%) while reporting 1000 → "1000\n" received intact; char_data stable and char_valid held during every stall.
- done held high for 500 cycles, plus a done pulse during CONVERT → exactly one report. Drop done, raise it again → second report.
- rst_n low for 1 cycle while in SEND after 3 bytes → char_valid=0 and busy=0 the next cycle. A fresh done edge then produces a full report from the first digit.
